fft_pwr_avg: RTL

Consumer-side companion of the `calc_pwr` power stage in `lib/dsp_fft`. It takes the per-bin power stream (re² + im²) of consecutive FFT frames and accumulates each bin over 2^N frames. At the end of the last frame of each block it emits one averaged spectrum frame through a valid/ready output with a small output FIFO. The input is a free-running FFT stream with no backpressure; output stalls are absorbed by the FIFO and reported when they overflow it.

---
 rtl/dsp_fft_pkg.sv | 23 ++
 rtl/fft_pwr_acc_ram.sv | 27 ++
 rtl/fft_pwr_avg.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dsp_fft_pkg.sv
// Shared definitions for the FFT power post-processing blocks:
// frame phase encoding and the averaging-exponent clamp.
package dsp_fft_pkg;

    // Role of the current frame inside an averaging block.
    typedef enum logic [1:0] {
        PH_FIRST = 2'd0,
        PH_ACCUM = 2'd1,
        PH_FINAL = 2'd2
    } phase_t;

    // Width of the averaging exponent as seen on the configuration port.
    localparam int AVG_CFG_WIDTH = 4;

    // Limit a requested averaging exponent to what the accumulator can hold.
    function automatic logic [AVG_CFG_WIDTH-1:0] clamp_avg_log2(
        input logic [AVG_CFG_WIDTH-1:0] cfg,
        input logic [AVG_CFG_WIDTH-1:0] max_log2
    );
        return (cfg > max_log2) ? max_log2 : cfg;
    endfunction

endpackage

// File: rtl/fft_pwr_acc_ram.sv
// Per-bin accumulator storage: simple dual-port RAM with one write port
// and one registered read port (read data valid one cycle after address).
module fft_pwr_acc_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 40
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int WORDS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // Write the accumulated value and register the read word every cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_pwr_avg.sv
// Averages the per-bin power stream of consecutive FFT frames over 2^N
// frames and emits one averaged spectrum per block through a small
// valid/ready output FIFO.  The input stream cannot be stalled.
// Optional build macro: FFT_PWR_AVG_ROUND_EN selects round-half-up
// instead of the default truncating (floor) shift.
module fft_pwr_avg
    import dsp_fft_pkg::*;
#(
    parameter int PWR_WIDTH    = 32,
    parameter int FFT_LOG2     = 10,
    parameter int AVG_LOG2_MAX = 8,
    parameter int ACC_WIDTH    = PWR_WIDTH + AVG_LOG2_MAX,
    parameter int OFIFO_LOG2   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           cfg_avg_log2,
    input  logic [PWR_WIDTH-1:0] i_power,
    input  logic                 i_valid,
    input  logic                 i_last,
    output logic [PWR_WIDTH-1:0] o_power,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic                 o_last,
    output logic                 o_overrun,
    output logic                 o_frame_err
);

`ifdef FFT_PWR_AVG_ROUND_EN
    localparam int SUM_WIDTH = ACC_WIDTH + 1;
`else
    localparam int SUM_WIDTH = ACC_WIDTH;
`endif
    localparam int FRM_EXT_WIDTH = AVG_LOG2_MAX + 1;
    localparam int DEPTH         = 1 << OFIFO_LOG2;
    localparam int CNT_WIDTH     = OFIFO_LOG2 + 1;

    // Input-side position and block configuration
    logic [FFT_LOG2-1:0]      bin_idx;
    logic [AVG_LOG2_MAX-1:0]  frm_idx;
    logic [3:0]               n_lat;
    logic [3:0]               n_cur;
    logic [FRM_EXT_WIDTH-1:0] last_frm;
    logic                     block_start;
    logic                     bin_max;
    logic                     is_final;
    logic                     len_err;
    phase_t                   phase;

    // Second pipeline stage (RAM read data arrives here)
    logic                     s2_valid;
    phase_t                   s2_phase;
    logic                     s2_first;
    logic                     s2_last;
    logic [FFT_LOG2-1:0]      s2_bin;
    logic [PWR_WIDTH-1:0]     s2_power;
    logic [3:0]               s2_n;

    // Accumulation datapath
    logic [ACC_WIDTH-1:0]     ram_rdata;
    logic                     ram_wr_en;
    logic [SUM_WIDTH-1:0]     acc_base;
    logic [SUM_WIDTH-1:0]     acc_sum;
    logic [SUM_WIDTH-1:0]     acc_rnd;
    logic [PWR_WIDTH-1:0]     push_data;

    // Output FIFO
    logic [PWR_WIDTH:0]       fifo_mem [DEPTH];
    logic [OFIFO_LOG2-1:0]    wr_ptr;
    logic [OFIFO_LOG2-1:0]    rd_ptr;
    logic [CNT_WIDTH-1:0]     fifo_cnt;
    logic                     fifo_full;
    logic                     push_req;
    logic                     push_ok;
    logic                     pop_mem;

    // Decode where the current beat sits: block start, frame end, phase, length errors.
    always_comb begin
        block_start = (frm_idx == '0) && (bin_idx == '0);
        n_cur       = block_start ? clamp_avg_log2(cfg_avg_log2, 4'(AVG_LOG2_MAX)) : n_lat;
        last_frm    = (FRM_EXT_WIDTH'(1) << n_cur) - FRM_EXT_WIDTH'(1);
        is_final    = ({1'b0, frm_idx} == last_frm);
        bin_max     = (bin_idx == '1);
        len_err     = i_valid && (i_last != bin_max);
        if (is_final) begin
            phase = PH_FINAL;
        end else if (frm_idx == '0) begin
            phase = PH_FIRST;
        end else begin
            phase = PH_ACCUM;
        end
    end

    // Track bin/frame position, latch the exponent per block, and discard blocks on length errors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_idx     <= '0;
            frm_idx     <= '0;
            n_lat       <= '0;
            o_frame_err <= 1'b0;
        end else if (i_valid) begin
            if (block_start) begin
                n_lat <= n_cur;
            end
            if (len_err) begin
                bin_idx     <= '0;
                frm_idx     <= '0;
                o_frame_err <= 1'b1;
            end else if (bin_max) begin
                bin_idx <= '0;
                frm_idx <= is_final ? '0 : frm_idx + 1'b1;
            end else begin
                bin_idx <= bin_idx + 1'b1;
            end
        end
    end

    // Carry the accepted beat to the cycle in which its RAM word is available.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_phase <= PH_FIRST;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_bin   <= '0;
            s2_power <= '0;
            s2_n     <= '0;
        end else begin
            s2_valid <= i_valid && !len_err;
            if (i_valid) begin
                s2_phase <= phase;
                s2_first <= (frm_idx == '0);
                s2_last  <= bin_max && is_final;
                s2_bin   <= bin_idx;
                s2_power <= i_power;
                s2_n     <= n_cur;
            end
        end
    end

    fft_pwr_acc_ram #(
        .ADDR_WIDTH (FFT_LOG2),
        .DATA_WIDTH (ACC_WIDTH)
    ) u_acc_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (s2_bin),
        .wr_data (ACC_WIDTH'(acc_sum)),
        .rd_addr (bin_idx),
        .rd_data (ram_rdata)
    );

    // Add the new power to the stored partial sum (zero base on the first frame) and scale on the final frame.
    always_comb begin
        acc_base = s2_first ? '0 : SUM_WIDTH'(ram_rdata);
        acc_sum  = acc_base + SUM_WIDTH'(s2_power);
`ifdef FFT_PWR_AVG_ROUND_EN
        acc_rnd  = (s2_n == 4'd0) ? '0 : (SUM_WIDTH'(1) << (s2_n - 4'd1));
`else
        acc_rnd  = '0;
`endif
        push_data = PWR_WIDTH'((acc_sum + acc_rnd) >> s2_n);
        ram_wr_en = s2_valid && (s2_phase != PH_FINAL);
        push_req  = s2_valid && (s2_phase == PH_FINAL);
        fifo_full = (fifo_cnt + CNT_WIDTH'(o_valid)) == CNT_WIDTH'(DEPTH);
        push_ok   = push_req && !fifo_full;
        pop_mem   = (fifo_cnt != '0) && (!o_valid || o_ready);
    end

    // Store pushed results; the output register counts as one of the FIFO slots.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= {s2_last, push_data};
        end
    end

    // Maintain FIFO pointers and occupancy, and flag results dropped on a full FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_mem) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_mem})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push_req && fifo_full) begin
                o_overrun <= 1'b1;
            end
        end
    end

    // Registered output stage: load the head of the FIFO whenever the current word is empty or taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid <= 1'b0;
            o_power <= '0;
            o_last  <= 1'b0;
        end else if (pop_mem) begin
            o_valid           <= 1'b1;
            {o_last, o_power} <= fifo_mem[rd_ptr];
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
